// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous waveform in i_clock cycles.
// One result per input period with a single-cycle valid strobe; overlong periods time out.
module clock_period_meter #(
  parameter int max_counter = 256,
  localparam int bits = ($clog2(max_counter) < 1) ? 1 : $clog2(max_counter)
) (
  input  logic            i_reset,
  input  logic            i_clock,
  input  logic            i_enable,
  input  logic            i_signal,
  output logic [bits-1:0] o_period,
  output logic [bits-1:0] o_high,
  output logic            o_valid,
  output logic            o_timeout,
  output logic            o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  localparam logic [bits-1:0] CNT_MAX = {bits{1'b1}};
  localparam logic [bits-1:0] CNT_ONE = {{(bits-1){1'b0}}, 1'b1};

  state_t state_q, state_d;
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic [bits-1:0] per_cnt_q, per_cnt_d;
  logic [bits-1:0] hi_cnt_q, hi_cnt_d;
  logic [bits-1:0] period_q, period_d;
  logic [bits-1:0] high_q, high_d;
  logic valid_q, valid_d;
  logic timeout_q, timeout_d;
  logic busy_q, busy_d;
  logic rise;

  assign rise = s2_q & ~s3_q;

  always_comb begin
    s1_d      = i_signal;
    s2_d      = s1_q;
    s3_d      = s2_q;
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    if (!i_enable) begin
      state_d   = IDLE;
      per_cnt_d = '0;
      hi_cnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          per_cnt_d = '0;
          hi_cnt_d  = '0;
          state_d   = ARM;
        end
        ARM: begin
          if (rise) begin
            per_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
            state_d   = MEASURE;
          end
        end
        MEASURE: begin
          // A rise closes the period even when the counter sits at max.
          if (rise) begin
            period_d  = per_cnt_q;
            high_d    = hi_cnt_q;
            valid_d   = 1'b1;
            per_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
          end else if (per_cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
            state_d   = ARM;
          end else begin
            per_cnt_d = per_cnt_q + CNT_ONE;
            if (s2_q && hi_cnt_q != CNT_MAX) begin
              hi_cnt_d = hi_cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          per_cnt_d = '0;
          hi_cnt_d  = '0;
        end
      endcase
    end
    busy_d = (state_d == MEASURE);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  assign o_period  = period_q;
  assign o_high    = high_q;
  assign o_valid   = valid_q;
  assign o_timeout = timeout_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: random and directed waveforms checked
// every cycle against a sample-history reference model.
module tb_clock_period_meter;

  localparam int MC   = 256;
  localparam int B    = ($clog2(MC) < 1) ? 1 : $clog2(MC);
  localparam int MAXP = (1 << B) - 1;

  logic         i_reset  = 1'b1;
  logic         i_clock  = 1'b0;
  logic         i_enable = 1'b0;
  logic         i_signal = 1'b0;
  logic [B-1:0] o_period;
  logic [B-1:0] o_high;
  logic         o_valid;
  logic         o_timeout;
  logic         o_busy;

  clock_period_meter #(.max_counter(MC)) dut (
    .i_reset  (i_reset),
    .i_clock  (i_clock),
    .i_enable (i_enable),
    .i_signal (i_signal),
    .o_period (o_period),
    .o_high   (o_high),
    .o_valid  (o_valid),
    .o_timeout(o_timeout),
    .o_busy   (o_busy)
  );

  always #5 i_clock = ~i_clock;

  int checks = 0;
  int errors = 0;

  bit samp[$];
  int e0     = 0;
  int mode   = 0;
  int last_r = 0;
  int exp_per = 0;
  int exp_hi  = 0;
  bit exp_v  = 0;
  bit exp_t  = 0;

  task automatic check(string tag, int obs, int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Synchronised view of the input: samples before reset release read as 0.
  function automatic bit s(int k);
    if (k < e0 || k < 0) return 1'b0;
    return samp[k];
  endfunction

  // Decision at edge e sees the input sampled two edges earlier.
  task automatic model(bit v, bit en);
    int  e;
    bit  rise;
    e     = samp.size();
    rise  = s(e - 2) && !s(e - 3);
    exp_v = 0;
    exp_t = 0;
    if (!en) begin
      mode = 0;
    end else begin
      case (mode)
        0: mode = 1;
        1: if (rise) begin
          mode   = 2;
          last_r = e;
        end
        default: begin
          if (rise) begin
            exp_per = e - last_r;
            exp_hi  = 0;
            for (int j = last_r - 2; j <= e - 3; j++) exp_hi += s(j);
            if (exp_hi > MAXP) exp_hi = MAXP;
            exp_v  = 1;
            last_r = e;
          end else if (e - last_r == MAXP) begin
            exp_t = 1;
            mode  = 1;
          end
        end
      endcase
    end
    samp.push_back(v);
  endtask

  task automatic step(bit v, bit en);
    i_signal = v;
    i_enable = en;
    @(posedge i_clock);
    model(v, en);
    @(negedge i_clock);
    check("valid", o_valid, exp_v);
    check("timeout", o_timeout, exp_t);
    check("busy", o_busy, mode == 2);
    check("period", o_period, exp_per);
    check("high", o_high, exp_hi);
  endtask

  task automatic wave(int hi, int lo, int reps);
    repeat (reps) begin
      repeat (hi) step(1'b1, 1'b1);
      repeat (lo) step(1'b0, 1'b1);
    end
  endtask

  task automatic check_zero(string tag);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_timeout"}, o_timeout, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_period"}, o_period, 0);
    check({tag, "_high"}, o_high, 0);
  endtask

  initial begin
    #12;
    check_zero("rst");
    @(negedge i_clock);
    i_reset = 1'b0;
    e0 = samp.size();
    repeat (3) step(1'b0, 1'b0);

    // divider with top 10, then 7 high / 5 low square wave
    wave(1, 9, 6);
    wave(7, 5, 5);

    // single rise then held low until the counter runs out
    step(1'b1, 1'b1);
    repeat (300) step(1'b0, 1'b1);
    wave(1, 9, 3);

    // boundary periods 255 and 256
    wave(1, 254, 3);
    wave(1, 255, 3);
    wave(1, 9, 3);

    // enable dropped exactly on the edge that sees a rise
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    wave(3, 8, 4);

    // asynchronous reset mid-period
    wave(2, 6, 3);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    #2;
    i_reset = 1'b1;
    #1;
    check_zero("arst");
    @(posedge i_clock);
    @(posedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b0;
    e0      = samp.size();
    mode    = 0;
    exp_per = 0;
    exp_hi  = 0;
    wave(4, 7, 4);

    // random waveforms with occasional enable drops
    for (int n = 0; n < 60; n++) begin
      int hi;
      int lo;
      hi = $urandom_range(1, 20);
      lo = $urandom_range(1, 20);
      repeat (hi) step(1'b1, ($urandom_range(0, 40) != 0));
      repeat (lo) step(1'b0, ($urandom_range(0, 40) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
